// File: rtl/i2c_pkg.sv
// Shared types and constants for the register-pointer I2C target.
package i2c_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRack,
    StIgnore
  } i2c_state_t;

  localparam logic ACK      = 1'b0;
  localparam logic NACK     = 1'b1;
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchroniser, stability filter and edge pulses for one open-drain bus line.
module i2c_line_filter #(
  parameter int unsigned FILT = 3
) (
  input  logic clk,
  input  logic RESET_N,
  input  logic line,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = (FILT > 1) ? $clog2(FILT) : 1;

  logic          sync1, sync2, prev;
  logic [CW-1:0] cnt;

  // Idle bus lines are high, so reset to 1 to avoid a spurious edge on release.
  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      prev  <= 1'b1;
      cnt   <= '0;
    end else begin
      sync1 <= line;
      sync2 <= sync1;
      prev  <= level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign rise = level & ~prev;
  assign fall = ~level & prev;

endmodule

// File: rtl/i2c_slave_regs.sv
// Clk-oversampled I2C target: address match, pointer byte, auto-increment reads and writes.
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = 7'h05,
  parameter int unsigned REG_AW     = 4,
  parameter int unsigned FILT       = 3
) (
  input  logic              clk,
  input  logic              RESET_N,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic              wr_en,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [REG_AW-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              busy
);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;
  logic start_cond, stop_cond;

  i2c_line_filter #(.FILT(FILT)) u_scl_filt (
    .clk    (clk),
    .RESET_N(RESET_N),
    .line   (scl_i),
    .level  (scl),
    .rise   (scl_rise),
    .fall   (scl_fall)
  );

  i2c_line_filter #(.FILT(FILT)) u_sda_filt (
    .clk    (clk),
    .RESET_N(RESET_N),
    .line   (sda_i),
    .level  (sda),
    .rise   (sda_rise),
    .fall   (sda_fall)
  );

  assign start_cond = sda_fall & scl;
  assign stop_cond  = sda_rise & scl;

  i2c_state_t        state;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic [REG_AW-1:0] ptr;
  logic              rw;
  logic              ack_phase;  // ACK states: SDA already driven; RACK: master acked
  logic [7:0]        byte_in;

  assign byte_in = {shreg[6:0], sda};
  assign rd_addr = ptr;

  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      state     <= StIdle;
      bit_cnt   <= '0;
      shreg     <= '0;
      ptr       <= '0;
      rw        <= RW_WRITE;
      ack_phase <= 1'b0;
      sda_oe    <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (start_cond) begin
        state   <= StAddr;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy    <= 1'b1;
      end else if (stop_cond) begin
        state  <= StIdle;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        unique case (state)
          StIdle: ;
          StAddr, StPtr, StWdata: begin
            if (scl_rise) begin
              shreg   <= byte_in;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                ack_phase <= 1'b0;
                if (state == StAddr) begin
                  rw    <= byte_in[0];
                  state <= (byte_in[7:1] == SLAVE_ADDR) ? StAddrAck : StIgnore;
                end else if (state == StPtr) begin
                  ptr   <= byte_in[REG_AW-1:0];
                  state <= StPtrAck;
                end else begin
                  wr_en   <= 1'b1;
                  wr_addr <= ptr;
                  wr_data <= byte_in;
                  ptr     <= ptr + REG_AW'(1);
                  state   <= StWdataAck;
                end
              end
            end
          end
          StAddrAck, StPtrAck, StWdataAck: begin
            // First SCL fall drives ACK, second one ends the ACK bit.
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_oe    <= ~ACK;
                ack_phase <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
                bit_cnt   <= '0;
                if (state == StAddrAck && rw == RW_READ) begin
                  sda_oe <= ~rd_data[7];
                  shreg  <= {rd_data[6:0], 1'b0};
                  state  <= StRdata;
                end else begin
                  sda_oe <= 1'b0;
                  state  <= (state == StAddrAck) ? StPtr : StWdata;
                end
              end
            end
          end
          StRdata: begin
            if (scl_fall) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                sda_oe    <= 1'b0;
                ptr       <= ptr + REG_AW'(1);
                ack_phase <= 1'b0;
                state     <= StRack;
              end else begin
                sda_oe <= ~shreg[7];
                shreg  <= {shreg[6:0], 1'b0};
              end
            end
          end
          StRack: begin
            if (scl_rise) begin
              if (sda == NACK) state <= StIgnore;
              else             ack_phase <= 1'b1;
            end else if (scl_fall && ack_phase) begin
              ack_phase <= 1'b0;
              bit_cnt   <= '0;
              sda_oe    <= ~rd_data[7];
              shreg     <= {rd_data[6:0], 1'b0};
              state     <= StRdata;
            end
          end
          StIgnore: sda_oe <= 1'b0;
          default:  state <= StIdle;
        endcase
      end
    end
  end

endmodule
